// File: rtl/matrix_pkg.sv
// Shared sizing constants and FSM encoding for the matrix operand loader.
package matrix_pkg;

    // Element width; each result word has this width too.
    localparam int DATA_W = 32;
    // Width of the product returned by matrix_mult (two result words).
    localparam int RES_W  = 64;
    // Elements per 2x2 matrix.
    localparam int N_ELEM = 4;
    // Slot index width; two matrices give 8 slots, indexed 0..7.
    localparam int IDX_W  = 3;

    // Loader phases: fill operands, let the multiplier settle, stream the result.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        EVAL    = 2'd1,
        SEND_LO = 2'd2,
        SEND_HI = 2'd3
    } state_e;

    // True in the two states where a result word is being offered downstream.
    function automatic logic is_send(input state_e s);
        return (s == SEND_LO) || (s == SEND_HI);
    endfunction

endpackage

// File: rtl/matrix_operand_regs.sv
// Operand register bank: one register per matrix element slot, written one
// slot at a time. Slots 0..3 hold matrix 1, slots 4..7 hold matrix 2, both
// row-major. Contents are only replaced by writes, so a partially reloaded
// bank keeps the older words in the slots not yet rewritten.
module matrix_operand_regs
    import matrix_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int NW = 2 * N_ELEM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [DW-1:0]        wr_data_i,
    output logic [NW*DW-1:0]     words_o
);

    for (genvar gi = 0; gi < NW; gi++) begin : g_slot
        logic [DW-1:0] word_q;

        // Slot register: cleared by reset, loaded when its index is written.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
                word_q <= wr_data_i;
            end
        end

        assign words_o[gi*DW +: DW] = word_q;
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Write-side front end for the combinational matrix_mult block. Collects eight
// serial words into two 2x2 operand banks, holds them for one evaluation cycle
// while the multiplier settles, captures the 64-bit answer and returns it as
// a low word followed by a high word over a valid/ready handshake.
module matrix_operand_loader #(
    parameter int DATA_W = matrix_pkg::DATA_W,
    parameter int N_ELEM = matrix_pkg::N_ELEM,
    parameter int RES_W  = matrix_pkg::RES_W   // must be 2*DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] arr1_0,
    output logic [DATA_W-1:0] arr1_1,
    output logic [DATA_W-1:0] arr1_2,
    output logic [DATA_W-1:0] arr1_3,
    output logic [DATA_W-1:0] arr2_0,
    output logic [DATA_W-1:0] arr2_1,
    output logic [DATA_W-1:0] arr2_2,
    output logic [DATA_W-1:0] arr2_3,
    output logic              op_valid,
    input  logic [RES_W-1:0]  ans,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_last
);

    import matrix_pkg::*;

    localparam int N_SLOT   = 2 * N_ELEM;
    localparam int LAST_IDX = N_SLOT - 1;

    state_e                  state_q;
    state_e                  state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [RES_W-1:0]        result_q;
    logic [RES_W-1:0]        result_d;
    logic                    in_accept;
    logic [N_SLOT*DATA_W-1:0] words;

    // Operand storage; written only by accepted input words.
    matrix_operand_regs #(
        .DW (DATA_W),
        .NW (N_SLOT)
    ) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (in_accept),
        .wr_idx_i  (idx_q),
        .wr_data_i (in_data),
        .words_o   (words)
    );

    // Next-state logic: clear overrides everything, including a word offered
    // in the same cycle (it is dropped) and a completing result handshake.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        result_d  = result_q;
        in_accept = 1'b0;
        if (clear) begin
            state_d = LOAD;
            idx_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        in_accept = 1'b1;
                        if (idx_q == IDX_W'(LAST_IDX)) begin
                            idx_d   = '0;
                            state_d = EVAL;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                EVAL: begin
                    // Operands have been stable for a full cycle; take the product.
                    result_d = ans;
                    state_d  = SEND_LO;
                end
                SEND_LO: begin
                    if (res_ready) begin
                        state_d = SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (res_ready) begin
                        state_d = LOAD;
                    end
                end
                default: begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State, slot index and captured result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    // Handshake flags decode straight from state, so they are glitch-free
    // and stay put until the state advances.
    assign in_ready  = (state_q == LOAD);
    assign op_valid  = (state_q == EVAL);
    assign res_valid = is_send(state_q);
    assign res_last  = (state_q == SEND_HI);

    // Result word mux; driven only from registered state, so it is stable
    // for as long as the word is offered.
    assign res_data = (state_q == SEND_HI) ? result_q[RES_W-1:DATA_W]
                                           : result_q[DATA_W-1:0];

    // Unpack the operand bank onto the row-major element ports.
    assign arr1_0 = words[0*DATA_W +: DATA_W];
    assign arr1_1 = words[1*DATA_W +: DATA_W];
    assign arr1_2 = words[2*DATA_W +: DATA_W];
    assign arr1_3 = words[3*DATA_W +: DATA_W];
    assign arr2_0 = words[4*DATA_W +: DATA_W];
    assign arr2_1 = words[5*DATA_W +: DATA_W];
    assign arr2_2 = words[6*DATA_W +: DATA_W];
    assign arr2_3 = words[7*DATA_W +: DATA_W];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader. The bench stands in for
// matrix_mult: ans is either a fixed word or a small product slice of the
// live operand outputs, and the expected result is computed from the words
// the bench sends.
module tb_matrix_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] arr1_0, arr1_1, arr1_2, arr1_3;
    logic [31:0] arr2_0, arr2_1, arr2_2, arr2_3;
    logic        op_valid;
    logic [63:0] ans;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        res_last;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc_cnt = 0;
    logic [32:0] sb [$];
    logic [32:0] sb_e;
    logic [31:0] w [8];
    logic [31:0] arr_o [8];
    bit          ans_const_en;
    logic [63:0] ans_const;
    int          a0;

    matrix_operand_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .arr1_0    (arr1_0),
        .arr1_1    (arr1_1),
        .arr1_2    (arr1_2),
        .arr1_3    (arr1_3),
        .arr2_0    (arr2_0),
        .arr2_1    (arr2_1),
        .arr2_2    (arr2_2),
        .arr2_3    (arr2_3),
        .op_valid  (op_valid),
        .ans       (ans),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_last  (res_last)
    );

    assign arr_o[0] = arr1_0;
    assign arr_o[1] = arr1_1;
    assign arr_o[2] = arr1_2;
    assign arr_o[3] = arr1_3;
    assign arr_o[4] = arr2_0;
    assign arr_o[5] = arr2_1;
    assign arr_o[6] = arr2_2;
    assign arr_o[7] = arr2_3;

    // Stand-in multiplier: {C[0][0], C[0][1]} of the 2x2 product, 32-bit wrap.
    function automatic logic [63:0] mm_model(input logic [31:0] a0_v, a1_v,
                                             input logic [31:0] b0_v, b1_v, b2_v, b3_v);
        logic [31:0] c00;
        logic [31:0] c01;
        c00 = a0_v * b0_v + a1_v * b2_v;
        c01 = a0_v * b1_v + a1_v * b3_v;
        return {c00, c01};
    endfunction

    assign ans = ans_const_en ? ans_const
                              : mm_model(arr1_0, arr1_1, arr2_0, arr2_1, arr2_2, arr2_3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: count accepted words, pop/compare each completed result word.
    always @(negedge clk) begin
        if (rst_n && !clear && in_valid && in_ready) begin
            acc_cnt++;
        end
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check_val("res_unexpected", 64'(sb.size()), 64'd1);
            end else begin
                sb_e = sb.pop_front();
                check_val("res_data", 64'(res_data), 64'(sb_e[31:0]));
                check_val("res_last", 64'(res_last), 64'(sb_e[32]));
                $display("[TB] result word %0h last=%0b", res_data, res_last);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one word starting at posedge+1; returns at posedge+1 after accept.
    task automatic drive_word(input logic [31:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        check_val("in_accept", 64'(ok), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        sync();
        drive_word(d);
    endtask

    // Load a full operand set, push the expected result, check EVAL timing.
    task automatic load_set(input bit gapped, input bit tail_valid, input logic [31:0] tail_data);
        logic [63:0] e;
        int          s0;
        sync();
        s0 = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            drive_word(w[i]);
            if (gapped && i < 7) sync();
        end
        if (tail_valid) begin
            in_valid = 1'b1;
            in_data  = tail_data;
        end
        e = ans_const_en ? ans_const : mm_model(w[0], w[1], w[4], w[5], w[6], w[7]);
        sb.push_back({1'b0, e[31:0]});
        sb.push_back({1'b1, e[63:32]});
        $display("[TB] loaded set, expect result %0h", e);
        @(negedge clk);
        check_val("op_valid_eval", 64'(op_valid), 64'd1);
        check_val("in_ready_eval", 64'(in_ready), 64'd0);
        for (int k = 0; k < 8; k++) check_val($sformatf("arr_%0d", k), 64'(arr_o[k]), 64'(w[k]));
        @(negedge clk);
        check_val("op_valid_pulse", 64'(op_valid), 64'd0);
        check_val("res_valid_lat", 64'(res_valid), 64'd1);
        check_val("accepts", 64'(acc_cnt - s0), 64'd8);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = (sb.size() == 0) && in_ready;
        end
        check_val("drain", 64'(done), 64'd1);
    endtask

    task automatic rand_words();
        for (int i = 0; i < 8; i++) w[i] = $urandom;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        res_ready = 1'b1; ans_const_en = 1'b0; ans_const = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_res_valid", 64'(res_valid), 64'd0);
        check_val("rst_op_valid", 64'(op_valid), 64'd0);
        check_val("rst_res_last", 64'(res_last), 64'd0);
        check_val("rst_res_data", 64'(res_data), 64'd0);

        // 1. Reset in the middle of a load.
        send_word(32'hA1); drive_word(32'hA2); drive_word(32'hA3);
        check_val("pre_rst_arr1_2", 64'(arr1_2), 64'hA3);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) check_val("midrst_arr", 64'(arr_o[k]), 64'd0);
        check_val("midrst_res_valid", 64'(res_valid), 64'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("midrst_in_ready", 64'(in_ready), 64'd1);

        // 2. Single set with a fixed product.
        for (int i = 0; i < 8; i++) w[i] = 32'(i + 1);
        ans_const_en = 1'b1;
        ans_const    = 64'h1122334455667788;
        load_set(1'b0, 1'b0, 32'h0);
        wait_drain();

        // 3. Backpressure in SEND_LO.
        rand_words();
        res_ready = 1'b0;
        load_set(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("bp_res_data", 64'(res_data), 64'h55667788);
            check_val("bp_res_valid", 64'(res_valid), 64'd1);
            check_val("bp_res_last", 64'(res_last), 64'd0);
            check_val("bp_in_ready", 64'(in_ready), 64'd0);
        end
        sync();
        wait_drain();

        // 4. Gapped input, multiplier driven by the live operands.
        ans_const_en = 1'b0;
        rand_words();
        load_set(1'b1, 1'b0, 32'h0);
        wait_drain();

        // 6. Words offered during EVAL/SEND are ignored.
        rand_words();
        res_ready = 1'b0;
        a0 = acc_cnt;
        load_set(1'b0, 1'b1, 32'hDEAD);
        repeat (3) @(negedge clk);
        check_val("ign_accepts", 64'(acc_cnt - a0), 64'd8);
        for (int k = 0; k < 8; k++) check_val("ign_arr", 64'(arr_o[k]), 64'(w[k]));
        sync();
        in_valid = 1'b0;
        wait_drain();
        rand_words();
        load_set(1'b0, 1'b0, 32'h0);
        wait_drain();

        // 5. Clear during SEND_HI, then a fresh set.
        rand_words();
        res_ready = 1'b0;
        load_set(1'b0, 1'b0, 32'h0);
        sync();
        res_ready = 1'b1;
        sync();
        res_ready = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        check_val("clr_in_send_hi", 64'(res_last), 64'd1);
        sync();
        clear = 1'b0;
        @(negedge clk);
        check_val("clr_res_valid", 64'(res_valid), 64'd0);
        check_val("clr_in_ready", 64'(in_ready), 64'd1);
        check_val("clr_op_valid", 64'(op_valid), 64'd0);
        check_val("clr_pending", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) void'(sb.pop_front());
        for (int k = 0; k < 8; k++) check_val("clr_arr_kept", 64'(arr_o[k]), 64'(w[k]));
        rand_words();
        load_set(1'b0, 1'b0, 32'h0);
        wait_drain();

        // Clear mid-load with a word offered in the same cycle: word dropped.
        send_word(32'hBEEF0001);
        drive_word(32'hBEEF0002);
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        clear    = 1'b1;
        a0       = acc_cnt;
        sync();
        clear    = 1'b0;
        in_valid = 1'b0;
        rand_words();
        load_set(1'b0, 1'b0, 32'h0);
        check_val("clr_drop_accepts", 64'(acc_cnt - a0), 64'd8);
        // Back-to-back set immediately after.
        rand_words();
        load_set(1'b0, 1'b0, 32'h0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
